// File: rtl/video_timing.sv
// Raster timing generator: pixel/line counters, syncs, display enable and scaled coordinates.
// Optional macro VIDEO_TIMING_FRAME_COUNT_EN adds an 8-bit frame counter output.
module video_timing #(
    parameter int H_VISIBLE    = 640,
    parameter int H_FRONT      = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BACK       = 48,
    parameter int V_VISIBLE    = 480,
    parameter int V_FRONT      = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BACK       = 33,
    parameter int H_SCALE_LOG2 = 2,
    parameter int V_SCALE_LOG2 = 2,
    parameter int SYNC_NEG     = 1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       pix_ce_i,
    output logic [9:0] hcount_o,
    output logic [9:0] vcount_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       display_on_o,
    output logic [7:0] hpos_o,
    output logic [6:0] vpos_o,
    output logic       line_start_o,
    output logic       frame_start_o
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    ,
    output logic [7:0] frame_count_o
`endif
);

    localparam logic [9:0] H_LAST     = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] H_SS       = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SE       = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SS       = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SE       = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic       SYNC_IDLE  = (SYNC_NEG != 0);

    logic [9:0] hcount_q, hcount_d;
    logic [9:0] vcount_q, vcount_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       display_q, display_d;
    logic [7:0] hpos_q, hpos_d;
    logic [6:0] vpos_q, vpos_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic       h_vis, v_vis;

    // Every output is derived from the next-state counters so it lines up with hcount/vcount.
    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_ce_i) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end
        h_vis         = (hcount_d < H_VIS);
        v_vis         = (vcount_d < V_VIS);
        display_d     = h_vis && v_vis;
        hsync_d       = (hcount_d >= H_SS && hcount_d < H_SE) ? ~SYNC_IDLE : SYNC_IDLE;
        vsync_d       = (vcount_d >= V_SS && vcount_d < V_SE) ? ~SYNC_IDLE : SYNC_IDLE;
        hpos_d        = h_vis ? 8'(hcount_d >> H_SCALE_LOG2) : '0;
        vpos_d        = v_vis ? 7'(vcount_d >> V_SCALE_LOG2) : '0;
        line_start_d  = pix_ce_i && (hcount_d == '0);
        frame_start_d = line_start_d && (vcount_d == '0);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hcount_q      <= H_LAST;
            vcount_q      <= V_LAST;
            hsync_q       <= SYNC_IDLE;
            vsync_q       <= SYNC_IDLE;
            display_q     <= 1'b0;
            hpos_q        <= '0;
            vpos_q        <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            display_q     <= display_d;
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    logic [7:0] frame_count_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            frame_count_q <= '0;
        end else if (frame_start_d) begin
            frame_count_q <= frame_count_q + 8'd1;
        end
    end

    assign frame_count_o = frame_count_q;
`endif

    assign hcount_o      = hcount_q;
    assign vcount_o      = vcount_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign display_on_o  = display_q;
    assign hpos_o        = hpos_q;
    assign vpos_o        = vpos_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: several geometries driven together, checked every pixel clock
// against a linear pixel-index model of the raster.
module tb_video_timing;

`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    localparam int NI = 3;
`else
    localparam int NI = 2;
`endif

    // Geometries: default VGA, small active-high, tiny (fast frame wrap)
    localparam int HV [3] = '{640, 16, 4};
    localparam int HF [3] = '{16,  4,  1};
    localparam int HS [3] = '{96,  6,  1};
    localparam int HB [3] = '{48,  6,  2};
    localparam int VV [3] = '{480, 12, 3};
    localparam int VF [3] = '{10,  2,  1};
    localparam int VS [3] = '{2,   2,  1};
    localparam int VB [3] = '{33,  3,  1};
    localparam int HL [3] = '{2,   2,  1};
    localparam int VL [3] = '{2,   1,  1};
    localparam int SN [3] = '{1,   0,  1};

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic pix_ce = 1'b0;

    logic [9:0] hc_w [NI];
    logic [9:0] vc_w [NI];
    logic       hs_w [NI];
    logic       vs_w [NI];
    logic       de_w [NI];
    logic [7:0] hp_w [NI];
    logic [6:0] vp_w [NI];
    logic       ls_w [NI];
    logic       fs_w [NI];
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    logic [7:0] fc_w [NI];
`endif

    always #5 clk = ~clk;

    genvar gi;
    for (gi = 0; gi < NI; gi++) begin : g_dut
        video_timing #(
            .H_VISIBLE(HV[gi]), .H_FRONT(HF[gi]), .H_SYNC(HS[gi]), .H_BACK(HB[gi]),
            .V_VISIBLE(VV[gi]), .V_FRONT(VF[gi]), .V_SYNC(VS[gi]), .V_BACK(VB[gi]),
            .H_SCALE_LOG2(HL[gi]), .V_SCALE_LOG2(VL[gi]), .SYNC_NEG(SN[gi])
        ) u_dut (
            .clk_i        (clk),
            .reset_i      (reset),
            .pix_ce_i     (pix_ce),
            .hcount_o     (hc_w[gi]),
            .vcount_o     (vc_w[gi]),
            .hsync_o      (hs_w[gi]),
            .vsync_o      (vs_w[gi]),
            .display_on_o (de_w[gi]),
            .hpos_o       (hp_w[gi]),
            .vpos_o       (vp_w[gi]),
            .line_start_o (ls_w[gi]),
            .frame_start_o(fs_w[gi])
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
            ,
            .frame_count_o(fc_w[gi])
`endif
        );
    end

    // Model: position is a single pixel index within the frame
    int p   [NI];
    bit mls [NI];
    bit mfs [NI];
    int mfc [NI];
    int checks = 0;
    int failures = 0;

    function automatic int htot(int i);
        return HV[i] + HF[i] + HS[i] + HB[i];
    endfunction

    function automatic int vtot(int i);
        return VV[i] + VF[i] + VS[i] + VB[i];
    endfunction

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s inst=%0d observed=%0d expected=%0d", tag, i, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            p[i]   = htot(i) * vtot(i) - 1;
            mls[i] = 1'b0;
            mfs[i] = 1'b0;
            mfc[i] = 0;
        end
    endtask

    task automatic model_clock(input bit ce);
        if (reset) begin
            model_reset();
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (ce) begin
                    p[i]   = (p[i] + 1) % (htot(i) * vtot(i));
                    mls[i] = (p[i] % htot(i)) == 0;
                    mfs[i] = (p[i] == 0);
                    if (mfs[i]) mfc[i] = (mfc[i] + 1) % 256;
                end else begin
                    mls[i] = 1'b0;
                    mfs[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            int h, v;
            bit hvis, vvis, hact, vact;
            h    = p[i] % htot(i);
            v    = p[i] / htot(i);
            hvis = h < HV[i];
            vvis = v < VV[i];
            hact = (h >= HV[i] + HF[i]) && (h < HV[i] + HF[i] + HS[i]);
            vact = (v >= VV[i] + VF[i]) && (v < VV[i] + VF[i] + VS[i]);
            chk("hcount", i, 32'(hc_w[i]), h);
            chk("vcount", i, 32'(vc_w[i]), v);
            chk("hsync", i, 32'(hs_w[i]), (hact ? 1 : 0) ^ SN[i]);
            chk("vsync", i, 32'(vs_w[i]), (vact ? 1 : 0) ^ SN[i]);
            chk("display_on", i, 32'(de_w[i]), (hvis && vvis) ? 1 : 0);
            chk("hpos", i, 32'(hp_w[i]), hvis ? (h >> HL[i]) : 0);
            chk("vpos", i, 32'(vp_w[i]), vvis ? (v >> VL[i]) : 0);
            chk("line_start", i, 32'(ls_w[i]), mls[i] ? 1 : 0);
            chk("frame_start", i, 32'(fs_w[i]), mfs[i] ? 1 : 0);
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
            chk("frame_count", i, 32'(fc_w[i]), mfc[i]);
`endif
        end
    endtask

    // Inputs change at the falling edge; outputs are checked at the next falling edge
    task automatic step(input bit ce);
        pix_ce = ce;
        @(posedge clk);
        model_clock(ce);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        step(1'b0);
        step(1'b1);
        reset = 1'b0;

        // idle after release: counters parked on the last pixel, no pulses
        repeat (10) step(1'b0);

        // continuous pixel enable: frame entry, first lines of default, many small frames
        repeat (1700) step(1'b1);

        // enable every 4th clock
        for (int k = 0; k < 400; k++) step((k % 4) == 0);

        // random enable pattern
        repeat (2000) step($urandom_range(0, 2) != 0);

        // mid-line asynchronous reset without a clock edge
        for (int k = 0; k < 2000 && hc_w[0] != 10'd300; k++) step(1'b1);
        chk("reach_h300", 0, 32'(hc_w[0]), 300);
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        step(1'b1);
        reset = 1'b0;

        // long run: tiny geometry passes 256 frames
        repeat (12300) step(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_timing.md
Name: video_timing

Overview:
Raster timing generator feeding the text/tile renderers. It counts pixels and lines for a VGA-style frame and produces hsync, vsync and display_on. It also produces the scaled logical coordinates hpos[7:0] and vpos[6:0] that the character buffer stage consumes. A clock enable divides the system clock down to the pixel rate, so one clk domain serves both this block and the downstream 4-cycle fetch pipeline.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 33, vertical back porch (lines)
H_SCALE_LOG2, 2, hpos = hcount >> H_SCALE_LOG2; (H_VISIBLE>>H_SCALE_LOG2) must be <= 256
V_SCALE_LOG2, 2, vpos = vcount >> V_SCALE_LOG2; (V_VISIBLE>>V_SCALE_LOG2) must be <= 128
SYNC_NEG, 1, 1 = syncs active-low, 0 = active-high

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
pix_ce  input  1  pixel clock enable; counters advance only on clk edges where pix_ce=1
hcount  output  10  raw pixel counter, 0..H_TOTAL-1
vcount  output  10  raw line counter, 0..V_TOTAL-1
hsync  output  1  horizontal sync, polarity per SYNC_NEG
vsync  output  1  vertical sync, polarity per SYNC_NEG
display_on  output  1  high when hcount<H_VISIBLE and vcount<V_VISIBLE
hpos  output  8  scaled column; 0 when hcount>=H_VISIBLE
vpos  output  7  scaled row; 0 when vcount>=V_VISIBLE
line_start  output  1  one-clk pulse when hcount enters 0
frame_start  output  1  one-clk pulse when (hcount,vcount) enters (0,0)

Behaviour:
- H_TOTAL = sum of the four H_* parameters (800 at defaults); V_TOTAL = sum of the four V_* parameters (525 at defaults).
- Reset (async) loads hcount=H_TOTAL-1 and vcount=V_TOTAL-1, i.e. the last pixel of the frame.
  - At reset: hsync/vsync inactive, display_on=0, hpos=0, vpos=0, line_start=0, frame_start=0.
  - The first pix_ce after reset release wraps to (0,0) and fires frame_start.
- On each clk with pix_ce=1:
  - hcount increments; at H_TOTAL-1 it wraps to 0.
  - On that wrap vcount increments; at V_TOTAL-1 it wraps to 0.
- With pix_ce=0, every register holds, and line_start/frame_start are driven 0.
- All outputs are registered and computed from next-state counter values. They are therefore cycle-aligned with hcount/vcount, with zero lag.
- hsync is active for hcount in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (656..751 at defaults).
- vsync is active for vcount in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (490..491 at defaults). vsync changes on the same edge as the vcount change.
- hpos = truncated hcount>>H_SCALE_LOG2; vpos = truncated vcount>>V_SCALE_LOG2. Both are forced to 0 outside their visible range.
- line_start is high for exactly one clk after a pix_ce edge that sets hcount=0. frame_start is the same but additionally requires vcount=0.
- Simultaneous reset and pix_ce: reset wins.
- Reset asserted mid-frame returns immediately to the reset state; there is no partial-line completion.

Optional Feature:
- Macro: VIDEO_TIMING_FRAME_COUNT_EN.
- When defined: adds output frame_count [7:0], reset to 0. It increments on the same edge that raises frame_start and wraps 255->0. The first frame after reset therefore reads 1.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset check: assert reset, release, hold pix_ce=0 for 10 clk -> hcount=799, vcount=524, hsync=vsync=1 (SYNC_NEG=1), display_on=0, no pulses.
- Frame entry: pix_ce=1 continuously after release -> first edge gives (0,0), frame_start=1 and line_start=1 for one clk, display_on=1, hpos=0, vpos=0.
- Visible mapping: hcount=639, vcount=479 -> hpos=159, vpos=119. Next pixel hcount=640 -> display_on=0, hpos=0.
- Horizontal sync: hsync goes low at hcount=656 and high at 752. At hcount=799->0, vcount increments by 1 and line_start pulses once.
- Vertical sync and gating: vsync low exactly for vcount 490-491. pix_ce=1 only every 4th clk -> counters step once per 4 clk and pulses last 1 clk each.
- Mid-frame reset and frame counter: async reset at hcount=300, vcount=200 -> immediate return to (799,524). With VIDEO_TIMING_FRAME_COUNT_EN, 256 frames -> frame_count wraps to 0.
